// File: rtl/lcd_pattern_gen_pkg.sv
// Shared types and constants for the LCD test-pattern sequencer: mode codes,
// FSM state encoding, RGB565 packing and the eight-entry colour-bar palette.
package lcd_pkg;

  localparam logic [1:0] MODE_RAMP  = 2'd0;
  localparam logic [1:0] MODE_BARS  = 2'd1;
  localparam logic [1:0] MODE_BOX   = 2'd2;
  localparam logic [1:0] MODE_SOLID = 2'd3;

  typedef enum logic [2:0] {
    S_WAIT_READY = 3'd0,
    S_IDLE       = 3'd1,
    S_SETUP      = 3'd2,
    S_REQ        = 3'd3,
    S_WAIT       = 3'd4,
    S_NEXT       = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PH_BLUE  = 2'd0,
    PH_GREEN = 2'd1,
    PH_RED   = 2'd2
  } ramp_phase_t;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic logic [15:0] rgb565(input logic [4:0] r, input logic [5:0] g,
                                         input logic [4:0] b);
    return {r, g, b};
  endfunction

  function automatic logic [15:0] bar_palette(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_pattern_gen_if.sv
// Window/pixel request bus between the pattern sequencer (master) and the
// ST7735 driver (slave).
interface lcd_pattern_gen_if #(
  parameter int COORD_W = 16
);
  logic               LCD_READY;
  logic               IS_BUSY;
  logic               WRITE_EN;
  logic [15:0]        COLOR_PIXEL;
  logic [COORD_W-1:0] COLOR_X;
  logic [COORD_W-1:0] COLOR_Y;
  logic [COORD_W-1:0] COLOR_X_END;
  logic [COORD_W-1:0] COLOR_Y_END;

  modport master (
    input  LCD_READY, IS_BUSY,
    output WRITE_EN, COLOR_PIXEL, COLOR_X, COLOR_Y, COLOR_X_END, COLOR_Y_END
  );

  modport slave (
    output LCD_READY, IS_BUSY,
    input  WRITE_EN, COLOR_PIXEL, COLOR_X, COLOR_Y, COLOR_X_END, COLOR_Y_END
  );
endinterface

// File: rtl/lcd_pattern_gen_bar_color.sv
// Registered colour-bar palette lookup: 3-bit bar index in, RGB565 out one
// cycle later.
module lcd_bar_color
  import lcd_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic [2:0]  idx_i,
  output logic [15:0] color_o
);

  logic [15:0] color_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      color_q <= BAR_WHITE;
    end else begin
      color_q <= bar_palette(idx_i);
    end
  end

  assign color_o = color_q;

endmodule

// File: rtl/lcd_pattern_gen.sv
// Test-pattern sequencer issuing window-fill requests to the ST7735 driver
// with a req/ack handshake. Define LCD_PATGEN_BOX_EN to compile in box mode.
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int WIDTH     = 160,
  parameter int HEIGHT    = 120,
  parameter int COORD_W   = 16,
  parameter int RAMP_STEP = 1,
  parameter int N_BARS    = 8,
  parameter int BOX_INSET = 10
) (
  input  logic              SYSTEM_CLK,
  input  logic              RESET,
  input  logic              RUN,
  input  logic [1:0]        MODE,
  output logic              FRAME_DONE,
  lcd_pattern_gen_if.master lcd
);

  localparam int                 BAR_W    = WIDTH / N_BARS;
  localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(HEIGHT - 1);
  localparam logic [COORD_W-1:0] BAR_LEN  = COORD_W'(BAR_W - 1);
  localparam logic [15:0]        LAST_BAR = 16'(N_BARS - 1);

  if (RAMP_STEP < 1 || RAMP_STEP > 8) begin : g_bad_ramp_step
    $error("RAMP_STEP must be within 1..8");
  end
  if (N_BARS < 1 || N_BARS > WIDTH) begin : g_bad_n_bars
    $error("N_BARS must be within 1..WIDTH");
  end
  if (2 * BOX_INSET >= WIDTH || 2 * BOX_INSET >= HEIGHT) begin : g_bad_inset
    $error("BOX_INSET leaves no box inside the panel");
  end

  state_t             state_q;
  logic [1:0]         mode_q;
  logic [15:0]        step_q;
  ramp_phase_t        phase_q;
  logic [4:0]         ramp_r_q;
  logic [5:0]         ramp_g_q;
  logic [4:0]         ramp_b_q;
  logic               write_en_q;
  logic               frame_done_q;
  logic [15:0]        pixel_q;
  logic [COORD_W-1:0] x_q, y_q, x_end_q, y_end_q;

  logic [COORD_W-1:0] win_x_d, win_y_d, win_xe_d, win_ye_d, bar_x0_d;
  logic [15:0]        win_px_d;
  logic               is_last_d;
  logic [2:0]         bar_idx_d;
  logic [15:0]        bar_color;

  function automatic logic [4:0] sat5(input logic [4:0] v);
    logic [5:0] s;
    s = {1'b0, v} + 6'(RAMP_STEP);
    return (s > 6'd31) ? 5'd31 : s[4:0];
  endfunction

  function automatic logic [5:0] sat6(input logic [5:0] v);
    logic [6:0] s;
    s = {1'b0, v} + 7'(RAMP_STEP);
    return (s > 7'd63) ? 6'd63 : s[5:0];
  endfunction

  // The palette output is registered, so it is addressed with the step that
  // S_SETUP is about to use: 0 when leaving S_IDLE, step+1 when leaving S_NEXT.
  always_comb begin
    bar_idx_d = step_q[2:0];
    if (state_q == S_IDLE) begin
      bar_idx_d = 3'd0;
    end else if (state_q == S_NEXT) begin
      bar_idx_d = step_q[2:0] + 3'd1;
    end
  end

  lcd_bar_color u_bar_color (
    .clk     (SYSTEM_CLK),
    .srst    (RESET),
    .idx_i   (bar_idx_d),
    .color_o (bar_color)
  );

  always_comb begin
    win_x_d   = '0;
    win_y_d   = '0;
    win_xe_d  = X_MAX;
    win_ye_d  = Y_MAX;
    win_px_d  = 16'h0000;
    is_last_d = 1'b1;
    bar_x0_d  = COORD_W'(step_q) * COORD_W'(BAR_W);
    case (mode_q)
      MODE_RAMP: begin
        win_px_d  = rgb565(ramp_r_q, ramp_g_q, ramp_b_q);
        is_last_d = (phase_q == PH_RED) && (ramp_r_q == 5'd31);
      end
      MODE_BARS: begin
        win_x_d   = bar_x0_d;
        win_xe_d  = (step_q == LAST_BAR) ? X_MAX : bar_x0_d + BAR_LEN;
        win_px_d  = bar_color;
        is_last_d = (step_q == LAST_BAR);
      end
`ifdef LCD_PATGEN_BOX_EN
      MODE_BOX: begin
        is_last_d = (step_q == 16'd4);
        case (step_q[2:0])
          3'd1: begin
            win_x_d = COORD_W'(BOX_INSET);           win_y_d  = COORD_W'(BOX_INSET);
            win_xe_d = COORD_W'(WIDTH - 1 - BOX_INSET); win_ye_d = COORD_W'(BOX_INSET);
            win_px_d = 16'hFFFF;
          end
          3'd2: begin
            win_x_d = COORD_W'(BOX_INSET);           win_y_d  = COORD_W'(HEIGHT - 1 - BOX_INSET);
            win_xe_d = COORD_W'(WIDTH - 1 - BOX_INSET); win_ye_d = COORD_W'(HEIGHT - 1 - BOX_INSET);
            win_px_d = 16'hFFFF;
          end
          3'd3: begin
            win_x_d = COORD_W'(BOX_INSET);           win_y_d  = COORD_W'(BOX_INSET);
            win_xe_d = COORD_W'(BOX_INSET);          win_ye_d = COORD_W'(HEIGHT - 1 - BOX_INSET);
            win_px_d = 16'hFFFF;
          end
          3'd4: begin
            win_x_d = COORD_W'(WIDTH - 1 - BOX_INSET); win_y_d  = COORD_W'(BOX_INSET);
            win_xe_d = COORD_W'(WIDTH - 1 - BOX_INSET); win_ye_d = COORD_W'(HEIGHT - 1 - BOX_INSET);
            win_px_d = 16'hFFFF;
          end
          default: ;
        endcase
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge SYSTEM_CLK) begin
    if (RESET) begin
      state_q      <= S_WAIT_READY;
      mode_q       <= MODE_RAMP;
      step_q       <= '0;
      phase_q      <= PH_BLUE;
      ramp_r_q     <= '0;
      ramp_g_q     <= '0;
      ramp_b_q     <= '0;
      write_en_q   <= 1'b0;
      frame_done_q <= 1'b0;
      pixel_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      x_end_q      <= X_MAX;
      y_end_q      <= Y_MAX;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_WAIT_READY: begin
          if (lcd.LCD_READY && !lcd.IS_BUSY) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (RUN) begin
            mode_q   <= MODE;
            step_q   <= '0;
            phase_q  <= PH_BLUE;
            ramp_r_q <= '0;
            ramp_g_q <= '0;
            ramp_b_q <= '0;
            state_q  <= S_SETUP;
          end
        end
        S_SETUP: begin
          x_q        <= win_x_d;
          y_q        <= win_y_d;
          x_end_q    <= win_xe_d;
          y_end_q    <= win_ye_d;
          pixel_q    <= win_px_d;
          write_en_q <= 1'b1;
          state_q    <= S_REQ;
        end
        S_REQ: begin
          if (lcd.IS_BUSY) begin
            write_en_q <= 1'b0;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Raising FRAME_DONE here makes it visible exactly during S_NEXT.
          if (!lcd.IS_BUSY) begin
            frame_done_q <= is_last_d;
            state_q      <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (is_last_d) begin
            state_q <= S_IDLE;
          end else begin
            step_q  <= step_q + 16'd1;
            state_q <= S_SETUP;
            if (mode_q == MODE_RAMP) begin
              case (phase_q)
                PH_BLUE:  if (ramp_b_q == 5'd31) phase_q <= PH_GREEN; else ramp_b_q <= sat5(ramp_b_q);
                PH_GREEN: if (ramp_g_q == 6'd63) phase_q <= PH_RED;   else ramp_g_q <= sat6(ramp_g_q);
                default:  ramp_r_q <= sat5(ramp_r_q);
              endcase
            end
          end
        end
        default: state_q <= S_WAIT_READY;
      endcase
    end
  end

  assign lcd.WRITE_EN    = write_en_q;
  assign lcd.COLOR_PIXEL = pixel_q;
  assign lcd.COLOR_X     = x_q;
  assign lcd.COLOR_Y     = y_q;
  assign lcd.COLOR_X_END = x_end_q;
  assign lcd.COLOR_Y_END = y_end_q;
  assign FRAME_DONE      = frame_done_q;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Directed bench for lcd_pattern_gen: 4-cycle busy driver model, window
// monitor, and hand-computed expectations for every pattern mode.
module tb_lcd_pattern_gen;

  typedef struct packed {
    logic [15:0] x, y, xe, ye, px;
  } win_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       RESET = 1'b1;
  logic       RUN = 1'b0;
  logic       RUN7 = 1'b0;
  logic       lcd_ready = 1'b0;
  logic [1:0] MODE = 2'd0;
  logic [1:0] MODE7 = 2'd1;
  logic       FRAME_DONE, FRAME_DONE7;

  int busy_cnt = 0;
  int busy_cnt7 = 0;
  int checks = 0;
  int passes = 0;
  int fd_pulses = 0, fd_cycles = 0, stab_err = 0, good_gaps = 0, bad_gaps = 0;
  win_t wq[$];
  win_t wq7[$];

  lcd_pattern_gen_if #(.COORD_W(16)) lcd ();
  lcd_pattern_gen_if #(.COORD_W(16)) lcd7 ();

  assign lcd.LCD_READY  = lcd_ready;
  assign lcd.IS_BUSY    = (busy_cnt != 0);
  assign lcd7.LCD_READY = 1'b1;
  assign lcd7.IS_BUSY   = (busy_cnt7 != 0);

  lcd_pattern_gen u_dut (
    .SYSTEM_CLK (clk),
    .RESET      (RESET),
    .RUN        (RUN),
    .MODE       (MODE),
    .FRAME_DONE (FRAME_DONE),
    .lcd        (lcd)
  );

  lcd_pattern_gen #(.N_BARS(7)) u_dut7 (
    .SYSTEM_CLK (clk),
    .RESET      (RESET),
    .RUN        (RUN7),
    .MODE       (MODE7),
    .FRAME_DONE (FRAME_DONE7),
    .lcd        (lcd7)
  );

  // Driver model: accepts a request and stays busy for 4 cycles.
  initial begin
    forever begin
      @(posedge clk);
      if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
      else if (lcd.WRITE_EN) busy_cnt <= 4;
      if (busy_cnt7 > 0) busy_cnt7 <= busy_cnt7 - 1;
      else if (lcd7.WRITE_EN) busy_cnt7 <= 4;
    end
  end

  // Monitor: logs each request, checks output stability and the re-request gap.
  initial begin
    logic we_p, we7_p, busy_p, fd_p, gap_on;
    int gap, frame_win;
    win_t cur, now;
    we_p = 0; we7_p = 0; busy_p = 0; fd_p = 0; gap_on = 0;
    gap = 0; frame_win = 0; cur = '0;
    forever begin
      @(negedge clk);
      now = {lcd.COLOR_X, lcd.COLOR_Y, lcd.COLOR_X_END, lcd.COLOR_Y_END, lcd.COLOR_PIXEL};
      if (gap_on) gap++;
      if (busy_p && !lcd.IS_BUSY) begin
        gap_on = 1; gap = 0;
      end
      if (lcd.WRITE_EN && !we_p) begin
        if (frame_win > 0 && gap_on) begin
          if (gap == 3) good_gaps++;
          else bad_gaps++;
        end
        gap_on = 0;
        frame_win++;
        cur = now;
        wq.push_back(now);
      end else if ((lcd.WRITE_EN || lcd.IS_BUSY) && now != cur) begin
        stab_err++;
      end
      if (FRAME_DONE) begin
        fd_cycles++;
        if (!fd_p) fd_pulses++;
        frame_win = 0;
      end
      if (lcd7.WRITE_EN && !we7_p)
        wq7.push_back({lcd7.COLOR_X, lcd7.COLOR_Y, lcd7.COLOR_X_END, lcd7.COLOR_Y_END,
                       lcd7.COLOR_PIXEL});
      we_p = lcd.WRITE_EN; we7_p = lcd7.WRITE_EN; busy_p = lcd.IS_BUSY; fd_p = FRAME_DONE;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    $display("check %-22s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_wins(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (wq.size() < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(wq.size() >= target), 32'd1);
  endtask

  task automatic wait_frames(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (fd_pulses < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(fd_pulses >= target), 32'd1);
  endtask

  initial begin
    int base, bad;
    logic found;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_write_en", 32'(lcd.WRITE_EN), 32'd0);
    chk("rst_pixel", 32'(lcd.COLOR_PIXEL), 32'h0);
    chk("rst_x", 32'(lcd.COLOR_X), 32'd0);
    chk("rst_y", 32'(lcd.COLOR_Y), 32'd0);
    chk("rst_x_end", 32'(lcd.COLOR_X_END), 32'd159);
    chk("rst_y_end", 32'(lcd.COLOR_Y_END), 32'd119);
    chk("rst_frame_done", 32'(FRAME_DONE), 32'd0);

    // Ready low for 100 cycles: no request; the N_BARS=7 instance runs one frame
    RESET = 1'b0;
    RUN7 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wq7.size() >= 1) RUN7 = 1'b0;
    end
    chk("no_req_before_ready", 32'(wq.size()), 32'd0);

    // Ramp frame, MODE switched to bars on window 50
    lcd_ready = 1'b1;
    RUN = 1'b1;
    MODE = 2'd0;
    wait_wins(50, 2000, "ramp_win50_reached");
    MODE = 2'd1;
    wait_frames(1, 3000, "ramp_frame_done");
    chk("ramp_windows", 32'(wq.size()), 32'd128);
    bad = 0;
    for (int i = 0; i < 128; i++)
      if (wq[i].x != 0 || wq[i].y != 0 || wq[i].xe != 159 || wq[i].ye != 119) bad++;
    chk("ramp_full_screen", 32'(bad), 32'd0);
    chk("ramp_col_0", 32'(wq[0].px), 32'h0000);
    chk("ramp_col_1", 32'(wq[1].px), 32'h0001);
    chk("ramp_col_31", 32'(wq[31].px), 32'h001F);
    chk("ramp_col_33", 32'(wq[33].px), 32'h003F);
    chk("ramp_col_97", 32'(wq[97].px), 32'h0FFF);
    chk("ramp_col_127", 32'(wq[127].px), 32'hFFFF);
    chk("frame_done_pulses", 32'(fd_pulses), 32'd1);
    chk("frame_done_width", 32'(fd_cycles), 32'd1);

    // Next frame is bars; drop RUN once it has started
    wait_wins(129, 50, "bars_started");
    RUN = 1'b0;
    wait_frames(2, 400, "bars_frame_done");
    chk("bars_windows", 32'(wq.size()), 32'd136);
    chk("bar0_x", 32'(wq[128].x), 32'd0);
    chk("bar0_x_end", 32'(wq[128].xe), 32'd19);
    chk("bar0_y_end", 32'(wq[128].ye), 32'd119);
    chk("bar0_col", 32'(wq[128].px), 32'hFFFF);
    chk("bar1_x", 32'(wq[129].x), 32'd20);
    chk("bar1_col", 32'(wq[129].px), 32'hFFE0);
    chk("bar7_x", 32'(wq[135].x), 32'd140);
    chk("bar7_x_end", 32'(wq[135].xe), 32'd159);
    chk("bar7_col", 32'(wq[135].px), 32'h0000);
    repeat (40) @(negedge clk);
    chk("idle_after_run_low", 32'(wq.size()), 32'd136);
    chk("gap_not_3", 32'(bad_gaps), 32'd0);
    chk("gap_seen", 32'(good_gaps > 100), 32'd1);
    chk("window_stability", 32'(stab_err), 32'd0);

    // N_BARS=7 instance: remainder absorbed by last bar
    chk("bars7_windows", 32'(wq7.size()), 32'd7);
    chk("bars7_b0_x_end", 32'(wq7[0].xe), 32'd21);
    chk("bars7_b6_x", 32'(wq7[6].x), 32'd132);
    chk("bars7_b6_x_end", 32'(wq7[6].xe), 32'd159);
    chk("bars7_b6_col", 32'(wq7[6].px), 32'h001F);

    // Box mode (or solid when box is not compiled in)
    base = wq.size();
    MODE = 2'd2;
    RUN = 1'b1;
    wait_wins(base + 1, 50, "box_started");
    RUN = 1'b0;
    wait_frames(3, 400, "box_frame_done");
`ifdef LCD_PATGEN_BOX_EN
    chk("box_windows", 32'(wq.size() - base), 32'd5);
    chk("box_bg_col", 32'(wq[base].px), 32'h0000);
    chk("box_top_x", 32'(wq[base+1].x), 32'd10);
    chk("box_top_y", 32'(wq[base+1].y), 32'd10);
    chk("box_top_x_end", 32'(wq[base+1].xe), 32'd149);
    chk("box_top_y_end", 32'(wq[base+1].ye), 32'd10);
    chk("box_top_col", 32'(wq[base+1].px), 32'hFFFF);
    chk("box_right_x", 32'(wq[base+4].x), 32'd149);
    chk("box_right_y_end", 32'(wq[base+4].ye), 32'd109);
`else
    chk("box_off_windows", 32'(wq.size() - base), 32'd1);
    chk("box_off_col", 32'(wq[base].px), 32'h0000);
    chk("box_off_x_end", 32'(wq[base].xe), 32'd159);
    chk("box_off_y_end", 32'(wq[base].ye), 32'd119);
`endif

    // Reset while the driver is busy on bar 1
    base = wq.size();
    MODE = 2'd1;
    RUN = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (wq.size() >= base + 2 && lcd.IS_BUSY && lcd.WRITE_EN) found = 1'b1;
    end
    chk("busy_bar1_found", 32'(found), 32'd1);
    chk("pre_reset_x", 32'(lcd.COLOR_X), 32'd20);
    RESET = 1'b1;
    RUN = 1'b0;
    lcd_ready = 1'b0;
    @(negedge clk);
    chk("midrst_write_en", 32'(lcd.WRITE_EN), 32'd0);
    chk("midrst_x", 32'(lcd.COLOR_X), 32'd0);
    chk("midrst_x_end", 32'(lcd.COLOR_X_END), 32'd159);
    chk("midrst_pixel", 32'(lcd.COLOR_PIXEL), 32'h0);
    RESET = 1'b0;
    base = wq.size();
    repeat (30) @(negedge clk);
    chk("no_req_not_ready", 32'(wq.size()), 32'(base));
    lcd_ready = 1'b1;
    MODE = 2'd3;
    RUN = 1'b1;
    wait_wins(base + 1, 100, "solid_started");
    RUN = 1'b0;
    wait_frames(4, 200, "solid_frame_done");
    chk("solid_windows", 32'(wq.size() - base), 32'd1);
    chk("solid_x_end", 32'(wq[base].xe), 32'd159);
    chk("solid_y_end", 32'(wq[base].ye), 32'd119);
    chk("solid_col", 32'(wq[base].px), 32'h0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lcd_pattern_gen.md
# lcd_pattern_gen

Parametrised test-pattern sequencer that drives the ST7735 driver's window/pixel request interface. It replaces ad-hoc colour stepping on the driver's busy edge with a fully synchronous request/acknowledge handshake. It offers selectable patterns: full-screen RGB ramp, vertical colour bars, and boxed outline. It sits between the board top level and the ST7735 driver, and has no SPI knowledge.

## Interface
- WIDTH, 160: panel width in pixels.
- HEIGHT, 120: panel height in pixels.
- COORD_W, 16: coordinate output width.
- RAMP_STEP, 1: per-window colour increment in ramp mode (1..8).
- N_BARS, 8: number of vertical bars (1..WIDTH).
- BOX_INSET, 10: box outline inset from each panel edge, in pixels.

Ports:
- SYSTEM_CLK  in  1  sole clock.
- RESET  in  1  synchronous, active-high reset.
- LCD_READY  in  1  driver initialisation complete.
- IS_BUSY  in  1  driver filling a window.
- RUN  in  1  enable pattern generation.
- MODE  in  2  0 ramp, 1 bars, 2 box, 3 solid black.
- WRITE_EN  out  1  window-fill request to the driver.
- COLOR_PIXEL  out  16  RGB565 fill colour {r5,g6,b5}.
- COLOR_X, COLOR_Y  out  COORD_W  window start (inclusive).
- COLOR_X_END, COLOR_Y_END  out  COORD_W  window end (inclusive).
- FRAME_DONE  out  1  one-cycle pulse after the last window of a frame.

## Operation
- States:
  - S_WAIT_READY: wait for LCD_READY=1 and IS_BUSY=0, then go to S_IDLE.
  - S_IDLE: if RUN=1, latch MODE, set step=0, go to S_SETUP.
  - S_SETUP: load window and colour registers for the current step, go to S_REQ.
  - S_REQ: hold WRITE_EN=1 until IS_BUSY is sampled 1, then go to S_WAIT.
  - S_WAIT: wait for IS_BUSY=0, then go to S_NEXT.
  - S_NEXT: if the step was last in the frame, pulse FRAME_DONE and go to S_IDLE; otherwise step+1 and go to S_SETUP.
- Ramp mode (MODE=0): every window is full screen (0,0)-(WIDTH-1,HEIGHT-1).
  - Blue phase: b=0,RAMP_STEP,… saturating at 31.
  - Green phase: g ramps 0..63 with b=31.
  - Red phase: r ramps 0..31 with g=63, b=31.
  - A phase ends on the window where its channel reaches its maximum. Saturate; never wrap.
  - With RAMP_STEP=1: 32+64+32 = 128 windows per frame.
- Bars mode (MODE=1):
  - Bar width bw = WIDTH/N_BARS (integer divide, computed at elaboration).
  - Bar i spans x = i*bw .. i*bw+bw-1, full height. The last bar ends at WIDTH-1 and absorbs the remainder.
  - Colour index i mod 8: white, yellow, cyan, green, magenta, red, blue, black.
- Box mode (MODE=2): 5 windows.
  - Window 1: full-screen black.
  - Windows 2-5: white 1-pixel edges at inset BOX_INSET, in order top, bottom, left, right.
- Solid mode (MODE=3): one full-screen black window per frame.
- MODE changes mid-frame are ignored until the next S_IDLE.
- RUN=0 mid-frame: the current frame completes; the block then stays in S_IDLE.
- LCD_READY falling: no effect on an in-flight window. It is checked only in S_WAIT_READY.

## Timing
- Reset values:
  - WRITE_EN=0, COLOR_PIXEL=0, COLOR_X=0, COLOR_Y=0.
  - COLOR_X_END=WIDTH-1, COLOR_Y_END=HEIGHT-1.
  - FRAME_DONE=0, state S_WAIT_READY.
- Reset mid-window: WRITE_EN drops in the cycle after RESET is sampled. The block re-waits for IS_BUSY=0 before issuing any request.
- All coordinates and COLOR_PIXEL are registered. They are stable from S_SETUP through S_WAIT, and change only in S_SETUP.
- WRITE_EN rises 1 cycle after entering S_SETUP. It falls in the cycle after IS_BUSY is first sampled high.
- If IS_BUSY=1 is sampled in the first S_REQ cycle, WRITE_EN is high for exactly 1 cycle.
- Next-request latency: WRITE_EN rises exactly 3 cycles after the first cycle IS_BUSY is sampled low in S_WAIT.
- FRAME_DONE is high for 1 cycle in S_NEXT of the last window.

## Configuration
- LCD_PATGEN_BOX_EN: defined means box mode is compiled in.
- Undefined: box logic is absent, and MODE=2 behaves exactly as MODE=3 (one black full-screen window per frame).

## Structure
- Package lcd_pkg holds:
  - the RGB565 pack function;
  - the mode encoding constants;
  - the state encoding;
  - the 8-entry bar colour constants.
- One sub-module, lcd_bar_color: 3-bit index in, registered 16-bit RGB565 out.

## Test plan
- Driver model with a 4-cycle IS_BUSY; LCD_READY high after 100 cycles, RUN=1, MODE=0 -> 128 windows all (0,0)-(159,119); colours go 0x0000, 0x0001 … 0x001F, 0x003F … 0xFFFF; one FRAME_DONE pulse.
- MODE=1, N_BARS=8 -> bar 0 x 0..19 white 0xFFFF, bar 7 x 140..159 black 0x0000. With N_BARS=7 -> last bar x 132..159.
- Measure the gap from IS_BUSY sampled low to WRITE_EN rising -> exactly 3 cycles; window outputs stable while WRITE_EN or IS_BUSY is high.
- Switch MODE 0->1 on ramp window 50 -> ramp finishes all 128 windows; the next frame is bars.
- Assert RESET while IS_BUSY=1 -> WRITE_EN=0 next cycle and all outputs at reset values; no request until IS_BUSY=0 and LCD_READY=1.
- MODE=2 -> with LCD_PATGEN_BOX_EN: 5 windows, top edge (10,10)-(149,10) 0xFFFF. Without the macro: 1 black full-screen window.
